// File: rtl/mor1kx_store_buffer_drain.sv
// mor1kx_store_buffer_drain: drains the LSU store buffer onto the data bus as
// Wishbone B3 classic single writes, one outstanding cycle at a time.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   sb_empty_i             store buffer empty flag
//   sb_adr/dat/pc/bsel_i   head entry fields, valid the cycle after a pop
//   sb_read_o              pop strobe, one cycle per entry
//   drain_en_i             permission to start a new pop
//   wbm_*                  Wishbone master write port
//   busy_o                 engine active or entries still buffered
//   store_err_o            one-cycle pulse after a bus error
//   err_pc_o, err_adr_o    PC/address of the last faulting store
module mor1kx_store_buffer_drain #(
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sb_empty_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
    output logic                              sb_read_o,
    input  logic                              drain_en_i,
    output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_dat_o,
    output logic [OPTION_OPERAND_WIDTH/8-1:0] wbm_sel_o,
    output logic                              wbm_cyc_o,
    output logic                              wbm_stb_o,
    output logic                              wbm_we_o,
    output logic [2:0]                        wbm_cti_o,
    output logic [1:0]                        wbm_bte_o,
    input  logic                              wbm_ack_i,
    input  logic                              wbm_err_i,
    output logic                              busy_o,
    output logic                              store_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   err_pc_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   err_adr_o
);
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DISCARD} state_t;
    state_t                          state;
    logic [OPTION_OPERAND_WIDTH-1:0] pc;
    logic                            can_pop;
    assign can_pop = !sb_empty_i && drain_en_i;
    // err wins over ack; a faulting cycle never chains into the next pop
    assign sb_read_o = (state == IDLE && can_pop) ||
                       (state == WRITE && wbm_ack_i && !wbm_err_i && can_pop) ||
                       (state == DISCARD && !sb_empty_i);
    assign busy_o    = state != IDLE || !sb_empty_i;
    assign wbm_stb_o = wbm_cyc_o;
    assign wbm_we_o  = wbm_cyc_o;
    assign wbm_cti_o = 3'b111;
    assign wbm_bte_o = 2'b00;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
            wbm_cyc_o   <= 1'b0;
            pc          <= '0;
            store_err_o <= 1'b0;
            err_pc_o    <= '0;
            err_adr_o   <= '0;
        end else begin
            store_err_o <= 1'b0;
            case (state)
                IDLE: state <= can_pop ? FETCH : IDLE;
                FETCH: begin
                    wbm_adr_o <= sb_adr_i;
                    wbm_dat_o <= sb_dat_i;
                    wbm_sel_o <= sb_bsel_i;
                    pc        <= sb_pc_i;
                    wbm_cyc_o <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    if (wbm_err_i) begin
                        wbm_cyc_o   <= 1'b0;
                        store_err_o <= 1'b1;
                        err_pc_o    <= pc;
                        err_adr_o   <= wbm_adr_o;
                        state       <= DISCARD;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        state     <= can_pop ? FETCH : IDLE;
                    end
                end
                DISCARD: state <= sb_empty_i ? IDLE : DISCARD;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
